// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, ID-facing output,
// EX redirect input and the free-running counters.
// master = fetch unit, slave = surrounding pipeline / memory.
interface fetch_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              stall;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;

   logic              imem_rd;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_data;

   logic              if_valid;
   logic [ADDR_W-1:0] if_pc;
   logic [DATA_W-1:0] if_ins;

   logic [31:0]       cycle_count;
   logic [31:0]       ins_count;

   modport master (
      input  stall, redirect, redirect_pc, imem_data,
      output imem_rd, imem_addr, if_valid, if_pc, if_ins,
             cycle_count, ins_count
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_data,
      input  imem_rd, imem_addr, if_valid, if_pc, if_ins,
             cycle_count, ins_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues reads to a 1-cycle-latency instruction
// memory, buffers returned {pc, ins} pairs in a small FIFO and presents the
// head to ID with a valid/stall handshake. EX redirects flush the FIFO and
// squash the outstanding read. Issue is throttled so that the FIFO occupancy
// plus the outstanding read never exceeds DEPTH, so no push is ever dropped.
module fetch_unit #(
   parameter int                 ADDR_W   = 16,
   parameter int                 DATA_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter logic [DATA_W-1:0]  NOP_INS  = '0,
   parameter int                 DEPTH    = 2
) (
   input  logic     clk,
   input  logic     clr,
   fetch_if.master  bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef logic [PTR_W-1:0] ptr_t;
   localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] issue_pc;
   logic              inflight;

   logic [CNT_W-1:0]  count;
   ptr_t              rd_ptr;
   ptr_t              wr_ptr;
   logic [ADDR_W-1:0] pc_mem  [DEPTH];
   logic [DATA_W-1:0] ins_mem [DEPTH];

   logic              empty;
   logic              full;
   logic              pop;
   logic              push;
   logic              issue;
   logic [CNT_W:0]    occupancy;

   logic [31:0]       cycle_q;
   logic [31:0]       ins_q;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
   endfunction

   // Handshake, squash and issue-throttle decisions for this cycle.
   always_comb begin
      empty     = (count == '0);
      full      = (count == CNT_W'(DEPTH));
      pop       = !empty && !bus.stall && !bus.redirect;
      // A redirect squashes the word returning this cycle.
      push      = inflight && !bus.redirect;
      // Slots committed after this edge if we do not issue; pop implies
      // count >= 1 so this never underflows.
      occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
      issue     = !clr && !bus.redirect && (occupancy < (CNT_W+1)'(DEPTH));
   end

   // Drive the bus: memory address straight from fetch PC, ID view from the FIFO head.
   always_comb begin
      bus.imem_rd     = issue;
      bus.imem_addr   = fetch_pc;
      bus.if_valid    = !empty;
      bus.if_pc       = empty ? '0 : pc_mem[rd_ptr];
      bus.if_ins      = empty ? NOP_INS : ins_mem[rd_ptr];
      bus.cycle_count = cycle_q;
      bus.ins_count   = ins_q;
   end

   // Fetch PC: reset vector, redirect target (word aligned) or next sequential word.
   always_ff @(posedge clk) begin
      if (clr) begin
         fetch_pc <= RESET_PC;
      end else if (bus.redirect) begin
         fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (issue) begin
         fetch_pc <= fetch_pc + ADDR_W'(4);
      end
   end

   // Track the outstanding read and the PC it was issued from.
   always_ff @(posedge clk) begin
      if (clr) begin
         inflight <= 1'b0;
         issue_pc <= '0;
      end else begin
         // issue is already low during a redirect, which squashes the slot.
         inflight <= issue;
         if (issue) begin
            issue_pc <= fetch_pc;
         end
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer.
   always_ff @(posedge clk) begin
      if (clr || bus.redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FIFO storage; contents are only observed through the head when non-empty.
   always_ff @(posedge clk) begin
      if (!clr && push) begin
         pc_mem[wr_ptr]  <= issue_pc;
         ins_mem[wr_ptr] <= bus.imem_data;
      end
   end

   // Free-running cycle counter and delivered-instruction counter.
   always_ff @(posedge clk) begin
      if (clr) begin
         cycle_q <= '0;
         ins_q   <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (pop) begin
            ins_q <= ins_q + 32'd1;
         end
      end
   end

   // The issue throttle must make an overflowing push impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (clr)
      !(push && full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset/stream, stall fill, redirect flush,
// redirect during stall with back-to-back redirects, reset mid-operation,
// and PC wrap on an 8-bit address instance.
module tb_fetch_unit;

   logic clk;
   logic clr;
   logic clr8;

   int n_checks = 0;
   int n_pass   = 0;

   fetch_if #(.ADDR_W(16), .DATA_W(32)) bus ();
   fetch_if #(.ADDR_W(8),  .DATA_W(32)) bus8 ();

   fetch_unit #(
      .ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000),
      .NOP_INS(32'h0000_0000), .DEPTH(2)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   fetch_unit #(
      .ADDR_W(8), .DATA_W(32), .RESET_PC(8'h00),
      .NOP_INS(32'h0000_0000), .DEPTH(2)
   ) dut8 (
      .clk(clk),
      .clr(clr8),
      .bus(bus8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memories: word at address A holds 32'hA0000000 + A, 1-cycle latency.
   always @(posedge clk) begin
      if (bus.imem_rd) bus.imem_data <= 32'hA000_0000 + 32'(bus.imem_addr);
   end

   always @(posedge clk) begin
      if (bus8.imem_rd) bus8.imem_data <= 32'hA000_0000 + 32'(bus8.imem_addr);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_head(input string tag, input logic [15:0] pc, input logic [31:0] icnt);
      check({tag, "_valid"}, 64'(bus.if_valid), 64'd1);
      check({tag, "_pc"},    64'(bus.if_pc),    64'(pc));
      check({tag, "_ins"},   64'(bus.if_ins),   64'(32'hA000_0000 + 32'(pc)));
      check({tag, "_icnt"},  64'(bus.ins_count), 64'(icnt));
   endtask

   task automatic expect_head8(input string tag, input logic [7:0] pc);
      check({tag, "_valid"}, 64'(bus8.if_valid), 64'd1);
      check({tag, "_pc"},    64'(bus8.if_pc),    64'(pc));
      check({tag, "_ins"},   64'(bus8.if_ins),   64'(32'hA000_0000 + 32'(pc)));
   endtask

   task automatic expect_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(bus.if_valid),    64'd0);
      check({tag, "_pc"},    64'(bus.if_pc),       64'd0);
      check({tag, "_ins"},   64'(bus.if_ins),      64'd0);
      check({tag, "_cyc"},   64'(bus.cycle_count), 64'd0);
      check({tag, "_icnt"},  64'(bus.ins_count),   64'd0);
      check({tag, "_addr"},  64'(bus.imem_addr),   64'd0);
   endtask

   initial begin
      clr = 1'b1;
      clr8 = 1'b1;
      bus.stall = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus8.stall = 1'b0;
      bus8.redirect = 1'b0;
      bus8.redirect_pc = '0;

      // Reset and sequential stream
      tick();
      tick();
      #1;
      expect_reset_outputs("rst");
      check("rst_rd", 64'(bus.imem_rd), 64'd0);
      clr = 1'b0;
      #1;
      check("c0_valid", 64'(bus.if_valid), 64'd0);
      check("c0_rd",    64'(bus.imem_rd),  64'd1);
      check("c0_addr",  64'(bus.imem_addr), 64'h0);
      tick();
      #1;
      check("c1_valid", 64'(bus.if_valid), 64'd0);
      check("c1_addr",  64'(bus.imem_addr), 64'h4);
      check("c1_cyc",   64'(bus.cycle_count), 64'd1);
      tick();
      #1;
      expect_head("s0", 16'h0000, 32'd0);
      check("s0_cyc", 64'(bus.cycle_count), 64'd2);
      tick();
      #1;
      expect_head("s4", 16'h0004, 32'd1);
      tick();
      #1;
      expect_head("s8", 16'h0008, 32'd2);

      // Stall fill: head 8 with 12 in flight fills the two slots
      bus.stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_pc",   64'(bus.if_pc),     64'h8);
         check("stall_rd",   64'(bus.imem_rd),   64'd0);
         check("stall_icnt", 64'(bus.ins_count), 64'd2);
         tick();
      end
      bus.stall = 1'b0;
      #1;
      expect_head("rel8", 16'h0008, 32'd2);
      check("rel_rd",   64'(bus.imem_rd),   64'd1);
      check("rel_addr", 64'(bus.imem_addr), 64'h10);
      tick();
      #1;
      expect_head("rel12", 16'h000C, 32'd3);
      tick();
      #1;
      expect_head("rel16", 16'h0010, 32'd4);
      tick();
      #1;
      expect_head("rel20", 16'h0014, 32'd5);

      // Reset mid-operation: head 20, read of 24 outstanding
      clr = 1'b1;
      bus.stall = 1'b1;
      #1;
      check("mid_rd", 64'(bus.imem_rd), 64'd0);
      tick();
      #1;
      expect_reset_outputs("mid");
      clr = 1'b0;
      bus.stall = 1'b0;
      #1;
      check("mid_rd2", 64'(bus.imem_rd), 64'd1);
      tick();
      #1;
      check("mid_stale_valid", 64'(bus.if_valid), 64'd0);
      check("mid_cyc", 64'(bus.cycle_count), 64'd1);
      tick();
      #1;
      expect_head("m0", 16'h0000, 32'd0);
      tick();
      #1;
      expect_head("m4", 16'h0004, 32'd1);

      // Redirect flush while head is 4
      bus.redirect = 1'b1;
      bus.redirect_pc = 16'h0102;
      #1;
      check("rd_redir_rd", 64'(bus.imem_rd), 64'd0);
      tick();
      bus.redirect = 1'b0;
      #1;
      check("r1_valid", 64'(bus.if_valid),  64'd0);
      check("r1_addr",  64'(bus.imem_addr), 64'h0100);
      check("r1_rd",    64'(bus.imem_rd),   64'd1);
      check("r1_icnt",  64'(bus.ins_count), 64'd1);
      tick();
      #1;
      check("r2_valid", 64'(bus.if_valid), 64'd0);
      tick();
      #1;
      expect_head("r100", 16'h0100, 32'd1);
      tick();
      #1;
      expect_head("r104", 16'h0104, 32'd2);

      // Redirect under stall, then a second redirect the next cycle
      bus.stall = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 16'h0040;
      #1;
      check("bb0_rd", 64'(bus.imem_rd), 64'd0);
      tick();
      bus.redirect_pc = 16'h0080;
      #1;
      check("bb1_valid", 64'(bus.if_valid),  64'd0);
      check("bb1_addr",  64'(bus.imem_addr), 64'h0040);
      check("bb1_rd",    64'(bus.imem_rd),   64'd0);
      check("bb1_icnt",  64'(bus.ins_count), 64'd2);
      tick();
      bus.redirect = 1'b0;
      bus.stall = 1'b0;
      #1;
      check("bb2_valid", 64'(bus.if_valid),  64'd0);
      check("bb2_addr",  64'(bus.imem_addr), 64'h0080);
      check("bb2_icnt",  64'(bus.ins_count), 64'd2);
      tick();
      #1;
      check("bb3_valid", 64'(bus.if_valid), 64'd0);
      tick();
      #1;
      expect_head("bb80", 16'h0080, 32'd2);
      tick();
      #1;
      expect_head("bb84", 16'h0084, 32'd3);

      // PC wrap on the 8-bit instance
      clr8 = 1'b0;
      bus8.redirect = 1'b1;
      bus8.redirect_pc = 8'hF8;
      #1;
      check("w_rd", 64'(bus8.imem_rd), 64'd0);
      tick();
      bus8.redirect = 1'b0;
      #1;
      check("w1_addr",  64'(bus8.imem_addr), 64'hF8);
      check("w1_valid", 64'(bus8.if_valid),  64'd0);
      tick();
      #1;
      check("w2_valid", 64'(bus8.if_valid), 64'd0);
      tick();
      #1;
      expect_head8("wF8", 8'hF8);
      tick();
      #1;
      expect_head8("wFC", 8'hFC);
      tick();
      #1;
      expect_head8("w00", 8'h00);
      tick();
      #1;
      expect_head8("w04", 8'h04);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
